// File: rtl/btle_hci_pkg.sv
// Shared HCI constants, FSM state encodings and a length helper for btle_hci_host.
package btle_hci_pkg;

  localparam logic [7:0]  HCI_IND_CMD              = 8'h01;
  localparam logic [7:0]  HCI_IND_EVT              = 8'h04;
  localparam logic [15:0] HCI_OP_RESET             = 16'h0C03;
  localparam logic [15:0] HCI_OP_LE_SET_ADV_ENABLE = 16'h200A;
  localparam logic [7:0]  HCI_EVT_CMD_COMPLETE     = 8'h0E;

  typedef enum logic [2:0] {
    T_IDLE,
    T_IND,
    T_OPL,
    T_OPH,
    T_PLEN,
    T_PARAM,
    T_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_CODE,
    R_PLEN,
    R_PARAM
  } rx_state_t;

  // True when a declared parameter length fits in a buffer of max_len bytes.
  function automatic logic len_fits(input logic [7:0] len, input int unsigned max_len);
    return 32'(len) <= max_len;
  endfunction

endpackage

// File: rtl/btle_hci_evt_rx.sv
// HCI event parser: RX FSM, event parameter buffer and, when
// BTLE_HCI_HOST_TIMEOUT_EN is defined, an inter-byte watchdog.
module btle_hci_evt_rx
  import btle_hci_pkg::*;
#(
  parameter int unsigned MAX_PARAM_LEN        = 64,
  parameter int unsigned PARAM_ADDR_BIT_WIDTH = 6,
  parameter int unsigned TIMEOUT_CYCLES       = 16000
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [7:0]                      i_rx_byte,
  input  logic                            i_rx_byte_valid,
  input  logic [PARAM_ADDR_BIT_WIDTH-1:0] i_rd_addr,
  output logic [7:0]                      o_rd_data,
  output logic [7:0]                      o_evt_code,
  output logic [7:0]                      o_evt_param_len,
  output logic                            o_evt_valid,
  output logic                            o_evt_error
);

  rx_state_t  r_state, w_state_nxt, w_cur;
  logic [7:0] r_code, w_code_nxt;
  logic [7:0] r_plen, w_plen_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       w_wr_en, w_done, w_len_ok, w_timeout;
  logic [7:0] r_evt_code, r_evt_plen, r_rd_data;
  logic       r_evt_valid, r_evt_error;
  logic [7:0] r_mem [MAX_PARAM_LEN];

`ifdef BTLE_HCI_HOST_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wdog;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog <= '0;
    end else if (i_rx_byte_valid || (r_state == R_IDLE)) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // Fires on the cycle the counter would reach the limit, so the error
  // pulse lands exactly TIMEOUT_CYCLES edges after the last byte.
  assign w_timeout = (r_state != R_IDLE) && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_timeout_unused;
  assign w_timeout_unused = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
`endif

  // A timeout drops the parser to idle before the current byte is looked at.
  assign w_cur = w_timeout ? R_IDLE : r_state;

  always_comb begin
    w_state_nxt = w_cur;
    w_code_nxt  = r_code;
    w_plen_nxt  = r_plen;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_done      = 1'b0;
    if (i_rx_byte_valid) begin
      case (w_cur)
        R_IDLE: begin
          if (i_rx_byte == HCI_IND_EVT) w_state_nxt = R_CODE;
        end
        R_CODE: begin
          w_code_nxt  = i_rx_byte;
          w_state_nxt = R_PLEN;
        end
        R_PLEN: begin
          w_plen_nxt = i_rx_byte;
          w_cnt_nxt  = '0;
          if (i_rx_byte == 8'd0) begin
            w_done      = 1'b1;
            w_state_nxt = R_IDLE;
          end else begin
            w_state_nxt = R_PARAM;
          end
        end
        R_PARAM: begin
          w_wr_en   = 32'(r_cnt) < MAX_PARAM_LEN;
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt == r_plen - 8'd1) begin
            w_done      = 1'b1;
            w_state_nxt = R_IDLE;
          end
        end
        default: w_state_nxt = R_IDLE;
      endcase
    end
  end

  assign w_len_ok = len_fits(w_plen_nxt, MAX_PARAM_LEN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= R_IDLE;
      r_code      <= '0;
      r_plen      <= '0;
      r_cnt       <= '0;
      r_evt_code  <= '0;
      r_evt_plen  <= '0;
      r_evt_valid <= 1'b0;
      r_evt_error <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_code      <= w_code_nxt;
      r_plen      <= w_plen_nxt;
      r_cnt       <= w_cnt_nxt;
      r_evt_valid <= w_done && w_len_ok;
      r_evt_error <= (w_done && !w_len_ok) || w_timeout;
      if (w_done && w_len_ok) begin
        r_evt_code <= w_code_nxt;
        r_evt_plen <= w_plen_nxt;
      end
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_cnt[PARAM_ADDR_BIT_WIDTH-1:0]] <= i_rx_byte;
  end

  assign o_rd_data       = r_rd_data;
  assign o_evt_code      = r_evt_code;
  assign o_evt_param_len = r_evt_plen;
  assign o_evt_valid     = r_evt_valid;
  assign o_evt_error     = r_evt_error;

endmodule

// File: rtl/btle_hci_host.sv
// Host-side HCI endpoint: command serialiser toward UART TX plus the event
// parser. Optional RX watchdog enabled by defining BTLE_HCI_HOST_TIMEOUT_EN.
module btle_hci_host
  import btle_hci_pkg::*;
#(
  parameter int unsigned MAX_PARAM_LEN        = 64,
  parameter int unsigned PARAM_ADDR_BIT_WIDTH = 6,
  parameter int unsigned TIMEOUT_CYCLES       = 16000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [15:0]                     cmd_opcode,
  input  logic [7:0]                      cmd_param_len,
  input  logic                            cmd_param_wr_en,
  input  logic [PARAM_ADDR_BIT_WIDTH-1:0] cmd_param_wr_addr,
  input  logic [7:0]                      cmd_param_wr_data,
  input  logic                            cmd_start,
  output logic                            cmd_busy,
  output logic                            cmd_done,
  output logic                            cmd_error,
  output logic [7:0]                      tx_byte,
  output logic                            tx_byte_valid,
  input  logic                            tx_byte_ready,
  input  logic [7:0]                      rx_byte,
  input  logic                            rx_byte_valid,
  output logic [7:0]                      evt_code,
  output logic [7:0]                      evt_param_len,
  input  logic [PARAM_ADDR_BIT_WIDTH-1:0] evt_param_rd_addr,
  output logic [7:0]                      evt_param_rd_data,
  output logic                            evt_valid,
  output logic                            evt_error
);

  tx_state_t   r_state, w_state_nxt;
  logic [15:0] r_opcode;
  logic [7:0]  r_plen, r_idx, w_idx_nxt;
  logic        r_cmd_error;
  logic        w_latch, w_reject;
  logic [7:0]  w_tx_byte;
  logic        w_tx_valid;
  logic [7:0]  r_cmd_mem [MAX_PARAM_LEN];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_latch     = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      T_IDLE, T_DONE: begin
        w_state_nxt = T_IDLE;
        if (cmd_start) begin
          if (len_fits(cmd_param_len, MAX_PARAM_LEN)) begin
            w_latch     = 1'b1;
            w_state_nxt = T_IND;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      T_IND:  if (tx_byte_ready) w_state_nxt = T_OPL;
      T_OPL:  if (tx_byte_ready) w_state_nxt = T_OPH;
      T_OPH:  if (tx_byte_ready) w_state_nxt = T_PLEN;
      T_PLEN: begin
        w_idx_nxt = '0;
        if (tx_byte_ready) w_state_nxt = (r_plen == 8'd0) ? T_DONE : T_PARAM;
      end
      T_PARAM: begin
        if (tx_byte_ready) begin
          if (r_idx == r_plen - 8'd1) w_state_nxt = T_DONE;
          else                        w_idx_nxt   = r_idx + 8'd1;
        end
      end
      default: w_state_nxt = T_IDLE;
    endcase
  end

  // Handshake: a byte transfers on any edge where tx_byte_valid && tx_byte_ready.
  // Byte and valid are decoded from registered state only, so they cannot
  // change or drop until the sink has taken the byte.
  always_comb begin
    w_tx_byte  = '0;
    w_tx_valid = 1'b0;
    case (r_state)
      T_IND:   begin w_tx_valid = 1'b1; w_tx_byte = HCI_IND_CMD;    end
      T_OPL:   begin w_tx_valid = 1'b1; w_tx_byte = r_opcode[7:0];  end
      T_OPH:   begin w_tx_valid = 1'b1; w_tx_byte = r_opcode[15:8]; end
      T_PLEN:  begin w_tx_valid = 1'b1; w_tx_byte = r_plen;         end
      T_PARAM: begin
        w_tx_valid = 1'b1;
        w_tx_byte  = r_cmd_mem[r_idx[PARAM_ADDR_BIT_WIDTH-1:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= T_IDLE;
      r_opcode    <= '0;
      r_plen      <= '0;
      r_idx       <= '0;
      r_cmd_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cmd_error <= w_reject;
      if (w_latch) begin
        r_opcode <= cmd_opcode;
        r_plen   <= cmd_param_len;
      end
    end
  end

  // Parameters are frozen while a packet is on the wire.
  always_ff @(posedge clk) begin
    if (cmd_param_wr_en && !cmd_busy) r_cmd_mem[cmd_param_wr_addr] <= cmd_param_wr_data;
  end

  assign tx_byte       = w_tx_byte;
  assign tx_byte_valid = w_tx_valid;
  assign cmd_busy      = w_tx_valid;
  assign cmd_done      = (r_state == T_DONE);
  assign cmd_error     = r_cmd_error;

  btle_hci_evt_rx #(
    .MAX_PARAM_LEN        (MAX_PARAM_LEN),
    .PARAM_ADDR_BIT_WIDTH (PARAM_ADDR_BIT_WIDTH),
    .TIMEOUT_CYCLES       (TIMEOUT_CYCLES)
  ) u_evt_rx (
    .i_clk           (clk),
    .i_rst_n         (rst),
    .i_rx_byte       (rx_byte),
    .i_rx_byte_valid (rx_byte_valid),
    .i_rd_addr       (evt_param_rd_addr),
    .o_rd_data       (evt_param_rd_data),
    .o_evt_code      (evt_code),
    .o_evt_param_len (evt_param_len),
    .o_evt_valid     (evt_valid),
    .o_evt_error     (evt_error)
  );

endmodule

// File: tb/tb_btle_hci_host.sv
// Directed bench for btle_hci_host: TX bytes and RX events are checked
// against scoreboard queues filled when the stimulus is driven.
module tb_btle_hci_host;
  import btle_hci_pkg::*;

  localparam int unsigned MAXP = 64;
  localparam int unsigned AW   = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   cmd_opcode;
  logic [7:0]    cmd_param_len;
  logic          cmd_param_wr_en;
  logic [AW-1:0] cmd_param_wr_addr;
  logic [7:0]    cmd_param_wr_data;
  logic          cmd_start;
  logic          cmd_busy, cmd_done, cmd_error;
  logic [7:0]    tx_byte;
  logic          tx_byte_valid, tx_byte_ready;
  logic [7:0]    rx_byte;
  logic          rx_byte_valid;
  logic [7:0]    evt_code, evt_param_len;
  logic [AW-1:0] evt_param_rd_addr;
  logic [7:0]    evt_param_rd_data;
  logic          evt_valid, evt_error;

  // clock / reset
  always #5 clk = ~clk;

  btle_hci_host #(
    .MAX_PARAM_LEN        (MAXP),
    .PARAM_ADDR_BIT_WIDTH (AW),
    .TIMEOUT_CYCLES       (100)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_opcode        (cmd_opcode),
    .cmd_param_len     (cmd_param_len),
    .cmd_param_wr_en   (cmd_param_wr_en),
    .cmd_param_wr_addr (cmd_param_wr_addr),
    .cmd_param_wr_data (cmd_param_wr_data),
    .cmd_start         (cmd_start),
    .cmd_busy          (cmd_busy),
    .cmd_done          (cmd_done),
    .cmd_error         (cmd_error),
    .tx_byte           (tx_byte),
    .tx_byte_valid     (tx_byte_valid),
    .tx_byte_ready     (tx_byte_ready),
    .rx_byte           (rx_byte),
    .rx_byte_valid     (rx_byte_valid),
    .evt_code          (evt_code),
    .evt_param_len     (evt_param_len),
    .evt_param_rd_addr (evt_param_rd_addr),
    .evt_param_rd_data (evt_param_rd_data),
    .evt_valid         (evt_valid),
    .evt_error         (evt_error)
  );

  // scoreboard
  int          n_total = 0;
  int          n_pass  = 0;
  logic [7:0]  exp_q[$];
  logic [17:0] evt_exp_q[$];    // {error, valid, code, plen}
  logic [7:0]  cmd_shadow [MAXP];
  logic        stall_pend = 1'b0;
  logic [7:0]  stall_byte;
  logic [31:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("tx_hold_valid", 32'(tx_byte_valid), 32'd1);
        chk("tx_hold_byte", 32'(tx_byte), 32'(stall_byte));
      end
      if (tx_byte_valid && tx_byte_ready) begin
        mon_exp = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
        chk("tx_byte", 32'(tx_byte), mon_exp);
      end
      stall_pend = tx_byte_valid && !tx_byte_ready;
      stall_byte = tx_byte;
      if (evt_valid || evt_error) begin
        mon_exp = (evt_exp_q.size() != 0) ? 32'(evt_exp_q.pop_front()) : 32'hDEAD;
        chk("evt", 32'({evt_error, evt_valid, evt_code, evt_param_len}), mon_exp);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_param(input int addr, input logic [7:0] data);
    cmd_param_wr_en   = 1'b1;
    cmd_param_wr_addr = AW'(addr);
    cmd_param_wr_data = data;
    cmd_shadow[addr]  = data;
    tick(1);
    cmd_param_wr_en = 1'b0;
  endtask

  task automatic drive_cmd(input logic [15:0] op, input logic [7:0] len);
    if (32'(len) <= MAXP) begin
      exp_q.push_back(HCI_IND_CMD);
      exp_q.push_back(op[7:0]);
      exp_q.push_back(op[15:8]);
      exp_q.push_back(len);
      for (int i = 0; i < int'(len); i++) exp_q.push_back(cmd_shadow[i]);
    end
    cmd_opcode    = op;
    cmd_param_len = len;
    cmd_start     = 1'b1;
    tick(1);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (cmd_done) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    tick(1);
    rx_byte_valid = 1'b0;
  endtask

  task automatic read_evt(input int addr, input logic [7:0] exp, input string tag);
    evt_param_rd_addr = AW'(addr);
    tick(1);
    chk(tag, 32'(evt_param_rd_data), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic got;
    int   first;
    rst = 1'b1;
    cmd_opcode = '0; cmd_param_len = '0; cmd_param_wr_en = 1'b0;
    cmd_param_wr_addr = '0; cmd_param_wr_data = '0; cmd_start = 1'b0;
    tx_byte_ready = 1'b0; rx_byte = '0; rx_byte_valid = 1'b0; evt_param_rd_addr = '0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        32'({cmd_busy, cmd_done, cmd_error, tx_byte, tx_byte_valid, evt_code,
             evt_param_len, evt_param_rd_data, evt_valid, evt_error}), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(1);

    // 1: no parameters, ready high -> 4 valid cycles then done
    tx_byte_ready = 1'b1;
    drive_cmd(HCI_OP_RESET, 8'd0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("t1_valid_c%0d", c), 32'(tx_byte_valid), 32'(c <= 4));
      chk($sformatf("t1_busy_c%0d", c), 32'(cmd_busy), 32'(c <= 4));
      chk($sformatf("t1_done_c%0d", c), 32'(cmd_done), 32'(c == 5));
      tick(1);
    end
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // 2: stalls with ready 1010..., ignored start and ignored write mid-packet
    write_param(0, 8'h01);
    tx_byte_ready = 1'b1;
    drive_cmd(HCI_OP_LE_SET_ADV_ENABLE, 8'd1);
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (c == 2) begin
        cmd_param_wr_en = 1'b1; cmd_param_wr_addr = '0; cmd_param_wr_data = 8'hEE;
      end
      if (c == 3) begin
        cmd_opcode = HCI_OP_RESET; cmd_param_len = 8'd0; cmd_start = 1'b1;
      end
      @(negedge clk);
      if (cmd_done) got = 1'b1;
      tick(1);
      cmd_start = 1'b0;
      cmd_param_wr_en = 1'b0;
      tx_byte_ready = ~tx_byte_ready;
    end
    chk("t2_done_seen", 32'(got), 32'd1);
    tx_byte_ready = 1'b1;
    tick(3);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3: normal event after junk bytes
    evt_exp_q.push_back({1'b0, 1'b1, HCI_EVT_CMD_COMPLETE, 8'd4});
    send_rx(8'hAA); send_rx(8'h55); send_rx(8'h04); send_rx(8'h0E);
    send_rx(8'h04); send_rx(8'h01); send_rx(8'h03); send_rx(8'h0C); send_rx(8'h00);
    tick(2);
    chk("t3_evt_drained", 32'(evt_exp_q.size()), 32'd0);
    read_evt(0, 8'h01, "t3_rd0");
    read_evt(1, 8'h03, "t3_rd1");
    read_evt(2, 8'h0C, "t3_rd2");
    read_evt(3, 8'h00, "t3_rd3");

    // 4a: event exactly at capacity, then over-length event
    evt_exp_q.push_back({1'b0, 1'b1, HCI_EVT_CMD_COMPLETE, 8'd64});
    send_rx(8'h04); send_rx(8'h0E); send_rx(8'd64);
    for (int i = 0; i < 64; i++) send_rx(8'(i * 3 + 1));
    tick(2);
    chk("t4_full_evt_drained", 32'(evt_exp_q.size()), 32'd0);
    read_evt(0, 8'h01, "t4_full_rd0");
    read_evt(63, 8'hBE, "t4_full_rd63");
    evt_exp_q.push_back({1'b1, 1'b0, HCI_EVT_CMD_COMPLETE, 8'd64});
    send_rx(8'h04); send_rx(8'hFF); send_rx(8'h80);
    for (int i = 0; i < 128; i++) send_rx(8'(i) ^ 8'hA5);
    tick(2);
    chk("t4_ovf_evt_drained", 32'(evt_exp_q.size()), 32'd0);
    chk("t4_ovf_code_kept", 32'(evt_code), 32'h0E);
    read_evt(5, 8'hA0, "t4_ovf_rd5");
    read_evt(63, 8'h9A, "t4_ovf_rd63");

    // 4b: command too long is rejected, command at capacity goes out whole
    drive_cmd(HCI_OP_RESET, 8'd65);
    @(negedge clk);
    chk("t4_cmd_error", 32'(cmd_error), 32'd1);
    chk("t4_cmd_err_no_valid", 32'(tx_byte_valid), 32'd0);
    chk("t4_cmd_err_no_busy", 32'(cmd_busy), 32'd0);
    tick(1);
    @(negedge clk);
    chk("t4_cmd_error_pulse", 32'(cmd_error), 32'd0);
    chk("t4_cmd_err_idle", 32'(tx_byte_valid), 32'd0);
    tick(1);
    for (int i = 0; i < 64; i++) write_param(i, 8'($urandom_range(0, 255)));
    drive_cmd(HCI_OP_LE_SET_ADV_ENABLE, 8'd64);
    wait_done("t4_max_cmd_done", 100);
    tick(1);
    chk("t4_max_cmd_drained", 32'(exp_q.size()), 32'd0);

`ifdef BTLE_HCI_HOST_TIMEOUT_EN
    // 5: truncated event times out 100 edges after its last byte
    evt_exp_q.push_back({1'b1, 1'b0, HCI_EVT_CMD_COMPLETE, 8'd64});
    send_rx(8'h04); send_rx(8'h0E); send_rx(8'h04); send_rx(8'h01);
    first = 0;
    for (int k = 1; k <= 150 && first == 0; k++) begin
      tick(1);
      if (evt_error) first = k;
    end
    chk("t5_timeout_latency", 32'(first), 32'd100);
    tick(2);
    evt_exp_q.push_back({1'b0, 1'b1, HCI_EVT_CMD_COMPLETE, 8'd0});
    send_rx(8'h04); send_rx(8'h0E); send_rx(8'h00);
    tick(2);
    chk("t5_evt_drained", 32'(evt_exp_q.size()), 32'd0);
`else
    first = 0;
`endif

    // 6: reset during byte 3 of a command and in the middle of an event
    send_rx(8'h04); send_rx(8'h0E); send_rx(8'h02); send_rx(8'h55);
    tx_byte_ready = 1'b1;
    drive_cmd(HCI_OP_RESET, 8'd0);
    tick(2);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(tx_byte_valid), 32'd0);
    chk("t6_rst_busy", 32'(cmd_busy), 32'd0);
    chk("t6_rst_evt_code", 32'(evt_code), 32'd0);
    exp_q.delete();
    tick(2);
    rst = 1'b1;
    tick(1);
    drive_cmd(HCI_OP_RESET, 8'd0);
    wait_done("t6_cmd_done", 20);
    evt_exp_q.push_back({1'b0, 1'b1, HCI_EVT_CMD_COMPLETE, 8'd1});
    send_rx(8'h04); send_rx(8'h0E); send_rx(8'h01); send_rx(8'h77);
    tick(2);
    read_evt(0, 8'h77, "t6_rd0");

    chk("final_tx_q_empty", 32'(exp_q.size()), 32'd0);
    chk("final_evt_q_empty", 32'(evt_exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
